// File: rtl/mccoy_pkg.sv
// Shared definitions for the McCoy program sequencer and the McCoy core bench:
// word widths, the NOP word and the sequencer state encoding.
package mccoy_pkg;

   localparam int PC_W    = 6;
   localparam int INSTR_W = 6;

   localparam logic [INSTR_W-1:0] NOP_WORD = '0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CRST  = 3'd2,
      ST_RUN   = 3'd3,
      ST_PAUSE = 3'd4,
      ST_HALT  = 3'd5
   } seq_state_t;

   // The core is held in reset while no valid program is running.
   function automatic logic holds_core(input seq_state_t s);
      return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_CRST);
   endfunction

endpackage

// File: rtl/mccoy_imem.sv
// Instruction store: synchronous write port for the loader,
// asynchronous read port feeding the core's fetch.
module mccoy_imem
   import mccoy_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic               clk,
   input  logic               we,
   input  logic [PC_W-1:0]    waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [PC_W-1:0]    raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem [DEPTH];

   // NOTE: the array has no reset on purpose; contents past prog_len are never
   // presented to the core, and a reset-free array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mccoy_prog_sequencer.sv
// Program loader and run controller for the McCoy core: stores the program,
// holds the core in reset around loads/restarts and gates its clock enable.
module mccoy_prog_sequencer
   import mccoy_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int RST_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_start,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   input  logic               load_last,
   output logic               load_ready,
   input  logic               run,
   input  logic               step,
   input  logic               restart,
   input  logic               bp_en,
   input  logic [PC_W-1:0]    bp_addr,
   input  logic [PC_W-1:0]    core_pc,
   output logic [INSTR_W-1:0] core_instr,
   output logic               core_reset,
   output logic               core_clk_en,
   output logic [PC_W:0]      prog_len,
   output logic               halted,
   output logic [2:0]         state
);

   localparam int               CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(RST_CYCLES - 1);
   localparam logic [PC_W-1:0]  LAST_ADDR = PC_W'(DEPTH - 1);

   seq_state_t         cur_state;
   seq_state_t         nxt_state;
   logic [PC_W-1:0]    wr_ptr;
   logic [CNT_W-1:0]   crst_cnt;
   logic [INSTR_W-1:0] rd_data;
   logic               wr_en;
   logic               load_done;
   logic               at_end;
   logic               at_bp;
   logic               stop_hit;

   mccoy_imem #(.DEPTH(DEPTH)) u_imem (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (load_data),
      .raddr (core_pc),
      .rdata (rd_data)
   );

   assign wr_en     = (cur_state == ST_LOAD) && load_valid && load_ready;
   assign load_done = wr_en && (load_last || (wr_ptr == LAST_ADDR));
   assign at_end    = {1'b0, core_pc} >= prog_len;
   assign at_bp     = bp_en && (core_pc == bp_addr);
   assign stop_hit  = at_bp || at_end;

   // PCs outside the loaded program fetch NOP, never stale memory.
   assign core_instr = at_end ? NOP_WORD : rd_data;
   assign state      = cur_state;

   // NOTE: non-blocking assignments so every register samples pre-edge values;
   // blocking ones would make results depend on always_ff evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= ST_IDLE;
      else       cur_state <= nxt_state;
   end

   always_comb begin
      // NOTE: default first, so no path leaves nxt_state unassigned (no latch).
      nxt_state = cur_state;
      if (load_start) begin
         nxt_state = ST_LOAD;
      end else begin
         case (cur_state)
            ST_IDLE:  if (restart && (prog_len != '0)) nxt_state = ST_CRST;
            ST_LOAD:  if (load_done) nxt_state = ST_CRST;
            ST_CRST:  if (crst_cnt == '0) nxt_state = run ? ST_RUN : ST_PAUSE;
            ST_RUN: begin
               if (restart)       nxt_state = ST_CRST;
               else if (stop_hit) nxt_state = ST_HALT;
               else if (!run)     nxt_state = ST_PAUSE;
            end
            ST_PAUSE: begin
               if (restart)               nxt_state = ST_CRST;
               else if (run)              nxt_state = ST_RUN;
               else if (step && stop_hit) nxt_state = ST_HALT;
            end
            ST_HALT: begin
               if (restart)              nxt_state = ST_CRST;
               else if (step && !at_end) nxt_state = ST_PAUSE;
            end
            default:  nxt_state = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      core_clk_en = 1'b0;
      load_ready  = 1'b0;
      core_reset  = holds_core(cur_state);
      halted      = (cur_state == ST_HALT);
      if (!load_start) begin
         case (cur_state)
            ST_LOAD:  load_ready  = 1'b1;
            ST_RUN:   core_clk_en = !restart && run && !stop_hit;
            ST_PAUSE: core_clk_en = !restart && !run && step && !stop_hit;
            // A step out of HALT deliberately ignores the breakpoint.
            ST_HALT:  core_clk_en = !restart && step && !at_end;
            default:  core_clk_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         prog_len <= '0;
      end else if (load_start) begin
         wr_ptr   <= '0;
         prog_len <= '0;
      end else if (wr_en) begin
         wr_ptr   <= wr_ptr + 1'b1;
         prog_len <= prog_len + 1'b1;
      end
   end

   // Loaded on CRST entry so the core sees exactly RST_CYCLES reset cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crst_cnt <= '0;
      end else if ((nxt_state == ST_CRST) && (cur_state != ST_CRST)) begin
         crst_cnt <= CNT_INIT;
      end else if (crst_cnt != '0) begin
         crst_cnt <= crst_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_mccoy_prog_sequencer.sv
// Scoreboard bench for mccoy_prog_sequencer: a behavioural program/core model
// predicts every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_mccoy_prog_sequencer;
   import mccoy_pkg::*;

   localparam int DEPTH = 64;
   localparam int RSTC  = 2;
   localparam int M_IDLE = 0, M_LOAD = 1, M_CRST = 2, M_RUN = 3, M_PAUSE = 4, M_HALT = 5;

   logic               clk = 1'b0;
   logic               reset;
   logic               load_start, load_valid, load_last, load_ready;
   logic [INSTR_W-1:0] load_data;
   logic               run, step, restart, bp_en;
   logic [PC_W-1:0]    bp_addr, core_pc;
   logic [INSTR_W-1:0] core_instr;
   logic               core_reset, core_clk_en, halted;
   logic [PC_W:0]      prog_len;
   logic [2:0]         state;

   always #5 clk = ~clk;

   mccoy_prog_sequencer #(.DEPTH(DEPTH), .RST_CYCLES(RSTC)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .run         (run),
      .step        (step),
      .restart     (restart),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .core_pc     (core_pc),
      .core_instr  (core_instr),
      .core_reset  (core_reset),
      .core_clk_en (core_clk_en),
      .prog_len    (prog_len),
      .halted      (halted),
      .state       (state)
   );

   typedef struct packed {
      logic       en;
      logic       rst;
      logic       halt;
      logic       ready;
      logic [5:0] instr;
      logic [6:0] len;
      logic [2:0] st;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    en_seen  = 0;
   string phase    = "reset";
   bit    jumps    = 1'b0;

   // Reference model: program as an array plus a length, core as a PC counter.
   int         m_mode, m_len, m_wptr, m_rcnt, m_pc;
   logic [5:0] m_mem [DEPTH];
   logic [5:0] words [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      obs_t  e;
      obs_t  a;
      string t;
      if (core_clk_en === 1'b1) en_seen++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {core_clk_en, core_reset, halted, load_ready, core_instr, prog_len, state};
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard[%s] @%0t: got en=%b rst=%b halt=%b rdy=%b instr=%h len=%0d st=%0d, expected en=%b rst=%b halt=%b rdy=%b instr=%h len=%0d st=%0d",
                     t, $time, a.en, a.rst, a.halt, a.ready, a.instr, a.len, a.st,
                     e.en, e.rst, e.halt, e.ready, e.instr, e.len, e.st);
         end
      end
   end

   task automatic model_reset();
      m_mode = M_IDLE;
      m_len  = 0;
      m_wptr = 0;
      m_rcnt = 0;
      m_pc   = 0;
   endtask

   // One clock: predict this cycle's outputs from the rules, advance model and core.
   task automatic cycle();
      obs_t e;
      int   n_mode, n_len, n_wptr, n_rcnt;
      bit   at_end, at_bp, wr;
      at_end  = (m_pc >= m_len);
      at_bp   = bp_en && (m_pc == int'(bp_addr));
      e.en    = 1'b0;
      e.ready = 1'b0;
      e.rst   = (m_mode == M_IDLE) || (m_mode == M_LOAD) || (m_mode == M_CRST);
      e.halt  = (m_mode == M_HALT);
      e.instr = at_end ? 6'h00 : m_mem[m_pc];
      e.len   = 7'(m_len);
      e.st    = 3'(m_mode);
      n_mode = m_mode; n_len = m_len; n_wptr = m_wptr; n_rcnt = m_rcnt; wr = 1'b0;
      if (load_start) begin
         n_mode = M_LOAD; n_len = 0; n_wptr = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (restart && m_len != 0) begin n_mode = M_CRST; n_rcnt = RSTC; end
            M_LOAD: begin
               e.ready = 1'b1;
               if (load_valid) begin
                  wr = 1'b1; n_len = m_len + 1; n_wptr = m_wptr + 1;
                  if (load_last || m_wptr == DEPTH - 1) begin n_mode = M_CRST; n_rcnt = RSTC; end
               end
            end
            M_CRST: begin
               n_rcnt = m_rcnt - 1;
               if (n_rcnt == 0) n_mode = run ? M_RUN : M_PAUSE;
            end
            M_RUN: begin
               if (restart)               begin n_mode = M_CRST; n_rcnt = RSTC; end
               else if (at_bp || at_end)  n_mode = M_HALT;
               else if (!run)             n_mode = M_PAUSE;
               else                       e.en = 1'b1;
            end
            M_PAUSE: begin
               if (restart)   begin n_mode = M_CRST; n_rcnt = RSTC; end
               else if (run)  n_mode = M_RUN;
               else if (step) begin
                  if (at_bp || at_end) n_mode = M_HALT;
                  else                 e.en = 1'b1;
               end
            end
            M_HALT: begin
               if (restart)                begin n_mode = M_CRST; n_rcnt = RSTC; end
               else if (step && !at_end)   begin e.en = 1'b1; n_mode = M_PAUSE; end
            end
            default: ;
         endcase
      end
      exp_q.push_back(e);
      tag_q.push_back(phase);
      if (wr) m_mem[m_wptr] = load_data;
      @(posedge clk);
      if (e.rst)     m_pc = 0;
      else if (e.en) m_pc = (jumps && $urandom_range(0, 7) == 0) ?
                            int'($urandom_range(0, m_len + 1)) % DEPTH : (m_pc + 1) % DEPTH;
      m_mode = n_mode; m_len = n_len; m_wptr = n_wptr; m_rcnt = n_rcnt;
      #1;
      core_pc    = 6'(m_pc);
      load_start = 1'b0;
      step       = 1'b0;
      restart    = 1'b0;
      load_valid = 1'b0;
      load_last  = 1'b0;
      #1;
   endtask

   // Load the words queue (or n random words when it is empty) with random gaps.
   task automatic send_load(input int n, input bit use_last);
      load_start = 1'b1;
      cycle();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) cycle();
         load_valid = 1'b1;
         load_data  = (words.size() > 0) ? words[i] : 6'($urandom);
         load_last  = use_last && (i == n - 1);
         cycle();
      end
      words.delete();
   endtask

   task automatic async_reset();
      #4;
      reset = 1'b1;
      #1;
      check("arst_state", 32'(state), 0);
      check("arst_core_reset", 32'(core_reset), 1);
      check("arst_clk_en", 32'(core_clk_en), 0);
      check("arst_load_ready", 32'(load_ready), 0);
      check("arst_halted", 32'(halted), 0);
      check("arst_prog_len", 32'(prog_len), 0);
      check("arst_instr", 32'(core_instr), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset   = 1'b0;
      core_pc = '0;
      #1;
   endtask

   initial begin
      int en_base;
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
      run = 1'b0; step = 1'b0; restart = 1'b0; bp_en = 1'b0; bp_addr = '0; core_pc = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      model_reset();
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state), 0);
      check("rst_core_reset", 32'(core_reset), 1);
      check("rst_clk_en", 32'(core_clk_en), 0);
      check("rst_load_ready", 32'(load_ready), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_prog_len", 32'(prog_len), 0);
      check("rst_instr", 32'(core_instr), 0);
      reset = 1'b0;
      #1;

      phase = "load3";
      run = 1'b1;
      words = '{6'h05, 6'h0A, 6'h3F};
      send_load(3, 1'b1);
      check("load3_len", 32'(prog_len), 3);
      check("load3_crst", 32'(state), M_CRST);
      phase = "run3";
      repeat (8) cycle();
      check("end_halted", 32'(halted), 1);
      check("end_state", 32'(state), M_HALT);
      check("end_instr", 32'(core_instr), 0);
      step = 1'b1;
      cycle();
      check("end_step_ignored", 32'(state), M_HALT);

      phase = "bp";
      bp_en = 1'b1; bp_addr = 6'd2; restart = 1'b1;
      cycle();
      repeat (6) cycle();
      check("bp_halted", 32'(halted), 1);
      check("bp_pc", 32'(core_pc), 2);
      en_base = en_seen;
      step = 1'b1;
      cycle();
      check("bp_step_state", 32'(state), M_PAUSE);
      check("bp_step_pulses", 32'(en_seen - en_base), 1);

      phase = "full";
      run = 1'b0; bp_en = 1'b0;
      send_load(DEPTH, 1'b0);
      check("full_len", 32'(prog_len), 64);
      check("full_ready", 32'(load_ready), 0);
      load_valid = 1'b1; load_data = 6'h2A;
      cycle();
      check("full_65th", 32'(prog_len), 64);
      repeat (3) cycle();
      check("pause_state", 32'(state), M_PAUSE);
      phase = "step3";
      en_base = en_seen;
      repeat (3) begin
         step = 1'b1;
         cycle();
         repeat (2) cycle();
      end
      check("step3_pulses", 32'(en_seen - en_base), 3);
      run = 1'b1; step = 1'b1;
      cycle();
      check("run_step_pulses", 32'(en_seen - en_base), 3);
      repeat (5) cycle();
      check("run_state", 32'(state), M_RUN);

      phase = "abort";
      load_start = 1'b1;
      cycle();
      check("abort_state", 32'(state), M_LOAD);
      check("abort_core_reset", 32'(core_reset), 1);
      check("abort_len", 32'(prog_len), 0);
      load_valid = 1'b1; load_data = 6'h11;
      cycle();
      load_valid = 1'b1; load_data = 6'h22;
      cycle();
      async_reset();
      phase = "idle_restart";
      restart = 1'b1;
      cycle();
      check("idle_restart_ignored", 32'(state), M_IDLE);

      phase = "random";
      jumps = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) run = ~run;
         if ($urandom_range(0, 31) == 0) bp_en = ~bp_en;
         if ($urandom_range(0, 31) == 0) bp_addr = 6'($urandom_range(0, 12));
         step       = ($urandom_range(0, 5) == 0);
         restart    = ($urandom_range(0, 60) == 0);
         load_start = (i == 0) || ($urandom_range(0, 150) == 0);
         load_valid = ($urandom_range(0, 2) != 0);
         load_data  = 6'($urandom);
         load_last  = ($urandom_range(0, 7) == 0);
         cycle();
      end

      repeat (2) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
